// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with load handshake,
// shift-enable stall and ready/busy/done status.
module piso_tx #(
  parameter int n         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [n-1:0] din,
  input  logic         en,
  output logic         sout,
  output logic         sout_valid,
  output logic         ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [n-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic [n-1:0]  shifted;

  assign shifted = MSB_FIRST ? {shreg[n-2:0], 1'b0}
                             : {1'b0, shreg[n-1:1]};

  // Gate with sout_valid so the leftover last bit never leaks in DONE.
  assign sout = sout_valid &
                (MSB_FIRST ? shreg[n-1] : shreg[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout_valid <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            shreg      <= din;
            cnt        <= '0;
            state      <= SHIFT;
            sout_valid <= 1'b1;
            ready      <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            if (cnt == LAST) begin
              state      <= DONE;
              sout_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              shreg <= shifted;
              cnt   <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          sout_valid <= 1'b0;
          ready      <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB and LSB instances, scoreboard of
// expected serial bits, SIPO reassembly, stall/ignored-load/reset cases.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_m;
  logic       load_l;
  logic [3:0] din;
  logic       en;

  logic sm, vm, rm, bm, dm;
  logic sl, vl, rl, bl, dl;

  int tests = 0;
  int fails = 0;
  int lat;

  bit         qm[$];
  bit         ql[$];
  logic [3:0] sipo;
  bit         b;

  always #5 clk = ~clk;

  piso_tx #(.n(4), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .load(load_m), .din(din), .en(en),
    .sout(sm), .sout_valid(vm), .ready(rm), .busy(bm), .done(dm)
  );

  piso_tx #(.n(4), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .load(load_l), .din(din), .en(en),
    .sout(sl), .sout_valid(vl), .ready(rl), .busy(bl), .done(dl)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_msb(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) qm.push_back(w[i]);
  endtask

  task automatic push_lsb(input logic [3:0] w);
    for (int i = 0; i < 4; i++) ql.push_back(w[i]);
  endtask

  // Bits are consumed at an edge where valid and en are both high.
  task automatic tick();
    if (vm === 1'b1 && en === 1'b1 && qm.size() > 0) begin
      b = qm.pop_front();
      sipo = {sipo[2:0], sm};
    end
    if (vl === 1'b1 && en === 1'b1 && ql.size() > 0) begin
      b = ql.pop_front();
    end
    @(posedge clk);
    #1;
    if (vm === 1'b1) begin
      tests++;
      assert (qm.size() > 0) else begin
        fails++;
        $error("FAIL m_extra observed=%0b expected=none", sm);
      end
      if (qm.size() > 0) chk("m_sout", sm, qm[0]);
    end
    if (vl === 1'b1) begin
      tests++;
      assert (ql.size() > 0) else begin
        fails++;
        $error("FAIL l_extra observed=%0b expected=none", sl);
      end
      if (ql.size() > 0) chk("l_sout", sl, ql[0]);
    end
  endtask

  task automatic wait_done(input bit sel, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        load_m = 1'b0;
        load_l = 1'b0;
        din    = 4'h0;
      end
      if ((sel ? dl : dm) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    load_m = 1'b1;
    load_l = 1'b1;
    din    = 4'b1111;
    en     = 1'b1;
    sipo   = 4'h0;
    tick();
    tick();
    chk("rst_ready", rm, 1'b1);
    chk("rst_sout", sm, 1'b0);
    chk("rst_valid", vm, 1'b0);
    chk("rst_busy", bm, 1'b0);
    chk("rst_done", dm, 1'b0);
    chk("rst_l_ready", rl, 1'b1);
    rst    = 1'b0;
    load_m = 1'b0;
    load_l = 1'b0;
    tick();
    chk("no_capture", {rm, vm, bm}, 3'b100);

    // MSB-first word
    sipo = 4'h0;
    din = 4'b1011;
    load_m = 1'b1;
    push_msb(4'b1011);
    wait_done(1'b0, lat);
    chk("msb_lat", lat, 5);
    chk("msb_qempty", qm.size(), 0);
    chk("msb_sipo", sipo, 4'b1011);
    chk("msb_done_busy", {bm, vm, sm}, 3'b100);
    tick();
    chk("msb_done_pulse", dm, 1'b0);
    chk("msb_ready", rm, 1'b1);

    // LSB-first word
    din = 4'b1000;
    load_l = 1'b1;
    push_lsb(4'b1000);
    wait_done(1'b1, lat);
    chk("lsb_lat", lat, 5);
    chk("lsb_qempty", ql.size(), 0);
    tick();
    chk("lsb_ready", rl, 1'b1);

    // Stall three cycles after the first bit
    sipo = 4'h0;
    din = 4'b1010;
    load_m = 1'b1;
    push_msb(4'b1010);
    tick();
    load_m = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {vm, sm}, 2'b11);
    end
    en = 1'b1;
    lat = -1;
    for (int i = 5; i <= 20; i++) begin
      tick();
      if (dm === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("stall_lat", lat, 8);
    chk("stall_sipo", sipo, 4'b1010);
    tick();

    // Load during SHIFT is ignored
    sipo = 4'h0;
    din = 4'b1101;
    load_m = 1'b1;
    push_msb(4'b1101);
    tick();
    din = 4'b0110;
    tick();
    tick();
    load_m = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dm === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("ign_done_seen", lat >= 0, 1'b1);
    chk("ign_sipo", sipo, 4'b1101);
    chk("ign_qempty", qm.size(), 0);
    tick();
    chk("ign_idle", {rm, vm}, 2'b10);

    // Reset in the middle of a word
    din = 4'b1111;
    load_m = 1'b1;
    push_msb(4'b1111);
    tick();
    load_m = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qm.delete();
    chk("mid_rst_out", {sm, vm, rm, bm}, 4'b0010);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_rst_nodone", dm, 1'b0);
    end
    sipo = 4'h0;
    din = 4'b0101;
    load_m = 1'b1;
    push_msb(4'b0101);
    wait_done(1'b0, lat);
    chk("post_rst_lat", lat, 5);
    chk("post_rst_sipo", sipo, 4'b0101);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
